// File: rtl/key_pkg.sv
// Shared constants for the key reader: field offsets inside the IN status word.
package key_pkg;
  localparam int MAX_KEYS  = 8;
  localparam int LEVEL_LSB = 0;
  localparam int PEND_LSB  = 8;
  localparam int OVF_LSB   = 16;
endpackage

// File: rtl/key_debounce.sv
// One key: synchroniser with polarity normalisation, debounce counter,
// stable level and auto-repeat hold/period counters.
module key_debounce #(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic level,
  output logic key_event
);
  localparam logic INVERT   = (ACTIVE_LOW != 0);
  localparam int   DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int   HOLD_LIM = (REPEAT_DELAY > 0) ? REPEAT_DELAY : 1;
  localparam int   HOLD_W   = $clog2(HOLD_LIM + 1);
  localparam int   PER_W    = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LIM - 1);
  localparam logic [HOLD_W-1:0] HOLD_FULL = HOLD_W'(HOLD_LIM);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(REPEAT_PERIOD - 1);

  logic            sync_a, sync_b, pressed;
  logic [DB_W-1:0] db_cnt;
  logic            differ, accept, rise, fall, repeat_evt;

  assign differ    = (pressed != level);
  assign accept    = differ && (db_cnt == DB_LAST);
  assign rise      = accept && pressed;
  assign fall      = accept && !pressed;
  assign key_event = rise || repeat_evt;

  // Normalise polarity before the chain so reset (all zero) means released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      pressed <= 1'b0;
    end else begin
      sync_a  <= key_raw ^ INVERT;
      sync_b  <= sync_a;
      pressed <= sync_b;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else if (accept) begin
      level  <= pressed;
      db_cnt <= '0;
    end else if (differ) begin
      db_cnt <= db_cnt + DB_W'(1);
    end else begin
      db_cnt <= '0;
    end
  end

  generate
    if (REPEAT_DELAY > 0) begin : g_repeat
      logic [HOLD_W-1:0] hold_cnt;
      logic [PER_W-1:0]  per_cnt;

      assign repeat_evt = level &&
                          ((hold_cnt == HOLD_LAST) ||
                           ((hold_cnt == HOLD_FULL) && (per_cnt == PER_LAST)));

      // Hold counter saturates at the delay, then the period counter cycles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_cnt <= '0;
          per_cnt  <= '0;
        end else if (!level || fall) begin
          hold_cnt <= '0;
          per_cnt  <= '0;
        end else if (hold_cnt != HOLD_FULL) begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
          per_cnt  <= '0;
        end else if (per_cnt == PER_LAST) begin
          per_cnt  <= '0;
        end else begin
          per_cnt  <= per_cnt + PER_W'(1);
        end
      end
    end else begin : g_no_repeat
      assign repeat_evt = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/key_reader.sv
// Key input peripheral: debounced levels, sticky press flags with overflow,
// masked acknowledge, and a registered 32-bit status word for the core.
module key_reader
  import key_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [N_KEYS-1:0] KEYS,
  input  logic              ACK,
  input  logic [N_KEYS-1:0] ACK_MASK,
  output logic [31:0]       IN,
  output logic              EVENT
);
  logic [N_KEYS-1:0] level, key_evt, pend, ovf, ack_vec;
  logic [31:0]       word;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce #(
      .ACTIVE_LOW     (ACTIVE_LOW),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_debounce (
      .clk      (CLK),
      .rst_n    (RST_N),
      .key_raw  (KEYS[i]),
      .level    (level[i]),
      .key_event(key_evt[i])
    );
  end

  assign ack_vec = ACK ? ACK_MASK : '0;

  // Events set pending (overflow if already pending); a same-cycle event beats ACK.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend <= '0;
      ovf  <= '0;
    end else begin
      pend <= key_evt | (pend & ~ack_vec);
      ovf  <= ~ack_vec & (ovf | (key_evt & pend));
    end
  end

  // Assemble the status word; unused key positions and the top byte stay zero.
  always_comb begin
    word = '0;
    word[LEVEL_LSB +: N_KEYS] = level;
    word[PEND_LSB  +: N_KEYS] = pend;
    word[OVF_LSB   +: N_KEYS] = ovf;
  end

  // Output register stage for the core's IN port and the event line.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      IN    <= 32'h0;
      EVENT <= 1'b0;
    end else begin
      IN    <= word;
      EVENT <= |pend;
    end
  end
endmodule

// File: tb/tb_key_reader.sv
// Bench for key_reader: behavioural model checked every cycle, directed
// scenarios with literal expectations, then randomised key/ack traffic.
module tb_key_reader;
  localparam int NK = 4;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [NK-1:0] KEYS = '1;
  logic          ACK = 1'b0;
  logic [NK-1:0] ACK_MASK = '0;
  logic [31:0]   IN;
  logic          EVENT;

  int checks = 0;
  int errors = 0;

  key_reader #(
    .N_KEYS(NK), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .KEYS(KEYS), .ACK(ACK),
    .ACK_MASK(ACK_MASK), .IN(IN), .EVENT(EVENT)
  );

  always #5 CLK = ~CLK;

  // Behavioural model. hist[k] = pressed sample taken k+1 edges ago.
  // A level is accepted at edge t when the D samples from edges t-3..t-D-2
  // all disagree with the current stable level.
  logic [NK-1:0] hist [0:DB+1];
  logic [NK-1:0] m_stable, m_pend, m_ovf, new_stable, evt;
  int            m_rise [NK];
  int            t;
  logic [31:0]   m_in;
  logic          m_event;
  logic          all_diff, ackb;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int j = 0; j <= DB + 1; j++) hist[j] = '0;
      m_stable = '0; m_pend = '0; m_ovf = '0;
      m_in = 32'h0; m_event = 1'b0; t = 0;
      for (int k = 0; k < NK; k++) m_rise[k] = 0;
    end else begin
      m_in    = {8'h0, 4'h0, m_ovf, 4'h0, m_pend, 4'h0, m_stable};
      m_event = |m_pend;
      for (int k = 0; k < NK; k++) begin
        all_diff = 1'b1;
        for (int j = 2; j <= DB + 1; j++)
          if (hist[j][k] == m_stable[k]) all_diff = 1'b0;
        new_stable[k] = all_diff ? ~m_stable[k] : m_stable[k];
        evt[k] = 1'b0;
        if (!m_stable[k] && new_stable[k]) begin
          evt[k] = 1'b1;
          m_rise[k] = t;
        end else if (m_stable[k] && RD > 0 && (t - m_rise[k]) >= RD &&
                     ((t - m_rise[k] - RD) % RP) == 0) begin
          evt[k] = 1'b1;
        end
        ackb = ACK && ACK_MASK[k];
        if (evt[k]) begin
          if (ackb) m_ovf[k] = 1'b0;
          else if (m_pend[k]) m_ovf[k] = 1'b1;
          m_pend[k] = 1'b1;
        end else if (ackb) begin
          m_pend[k] = 1'b0;
          m_ovf[k]  = 1'b0;
        end
      end
      for (int j = DB + 1; j >= 1; j--) hist[j] = hist[j-1];
      hist[0] = ~KEYS;
      m_stable = new_stable;
      t++;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (RST_N) begin
      checks++;
      if (IN !== m_in || EVENT !== m_event) begin
        errors++;
        $display("FAIL model_cmp t=%0d IN=%h EVENT=%b expected IN=%h EVENT=%b",
                 t, IN, EVENT, m_in, m_event);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic ack_pulse(input logic [NK-1:0] m);
    @(negedge CLK); ACK = 1'b1; ACK_MASK = m;
    @(negedge CLK); ACK = 1'b0; ACK_MASK = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    // Reset state
    idle(3);
    chk("reset_in", IN, 32'h0);
    chk("reset_event", {31'h0, EVENT}, 32'h0);
    RST_N = 1'b1;
    idle(10);

    // Clean press of key0: visible exactly 7 edges after the first sample
    KEYS = 4'b1110;
    @(posedge CLK);                 // edge 0
    repeat (6) @(posedge CLK);      // edge 6
    #1 chk("press_edge6", IN, 32'h0);
    @(posedge CLK);                 // edge 7
    #1 chk("press_edge7", IN, 32'h0000_0101);
    chk("press_event", {31'h0, EVENT}, 32'h1);
    @(negedge CLK); KEYS = 4'b1111;
    idle(12);
    ack_pulse(4'b1111);
    idle(2);
    chk("cleared", IN, 32'h0);

    // Glitch shorter than the debounce window
    KEYS = 4'b1110;
    idle(3);
    KEYS = 4'b1111;
    idle(15);
    chk("glitch_in", IN, 32'h0);
    chk("glitch_event", {31'h0, EVENT}, 32'h0);

    // Overflow on key0, key1 pending, then masked ACK of key0 only
    KEYS = 4'b1100; idle(8);
    KEYS = 4'b1111; idle(10);
    KEYS = 4'b1110; idle(8);
    KEYS = 4'b1111; idle(12);
    chk("overflow", IN, 32'h0001_0300);
    ack_pulse(4'b0001);
    idle(2);
    chk("masked_ack", IN, 32'h0000_0200);

    // ACK of key1 on the very cycle its new press event fires
    KEYS = 4'b1101;
    @(posedge CLK);                 // edge 0
    repeat (5) @(posedge CLK);      // edge 5
    @(negedge CLK); ACK = 1'b1; ACK_MASK = 4'b0010;
    @(negedge CLK); ACK = 1'b0; ACK_MASK = '0;
    @(posedge CLK);                 // edge 7
    #1 chk("ack_and_event", IN, 32'h0000_0202);
    @(negedge CLK); KEYS = 4'b1111;
    idle(12);
    ack_pulse(4'b1111);
    idle(2);

    // Auto-repeat on key2 with random acknowledges while held
    KEYS = 4'b1011;
    for (int i = 0; i < 70; i++) begin
      @(negedge CLK);
      ACK = ($urandom_range(0, 3) == 0);
      ACK_MASK = 4'($urandom);
    end
    ACK = 1'b0; ACK_MASK = '0;
    KEYS = 4'b1111;
    idle(12);
    ack_pulse(4'b1111);
    idle(40);
    chk("no_repeat_after_release", IN, 32'h0);

    // Reset two cycles into a press; key held through reset release
    KEYS = 4'b0111; idle(10);
    KEYS = 4'b1110;
    @(posedge CLK);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1 chk("async_reset_in", IN, 32'h0);
    chk("async_reset_event", {31'h0, EVENT}, 32'h0);
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK);                 // edge 0
    repeat (6) @(posedge CLK);
    #1 chk("post_reset_edge6", IN, 32'h0);
    @(posedge CLK);
    #1 chk("post_reset_edge7", IN, 32'h0000_0101);

    // Randomised traffic against the model
    for (int s = 0; s < 40; s++) begin
      @(negedge CLK);
      KEYS = 4'($urandom);
      repeat ($urandom_range(1, 12)) begin
        @(negedge CLK);
        ACK = ($urandom_range(0, 4) == 0);
        ACK_MASK = 4'($urandom);
      end
    end
    ACK = 1'b0; ACK_MASK = '0;
    KEYS = 4'b1111;
    idle(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
